// File: rtl/crack_job_controller.sv
// Job sequencer for one guess generator: walks lengths min..max, buffers guesses in a small FIFO
// under credit flow control, streams them out, and reports hit/exhaustion/abort to the host.
module crack_job_controller #(
  parameter int unsigned GEN_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DRAIN_CYC  = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [2:0]   cfg_charset,
  input  logic [3:0]   cfg_min_len,
  input  logic [3:0]   cfg_max_len,
  output logic [2:0]   gen_charset,
  output logic [3:0]   gen_len,
  output logic         gen_reset,
  output logic         gen_step,
  input  logic [127:0] gen_guess,
  input  logic         gen_done,
  output logic [127:0] out_guess,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         hit,
  input  logic [127:0] hit_guess,
  output logic         busy,
  output logic         found,
  output logic [127:0] found_guess,
  output logic         exhausted,
  output logic         aborted,
  output logic [47:0]  guess_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + GEN_LAT + 2);
  localparam int unsigned DrnW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StNextLen, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          charset_q;
  logic [3:0]          len_q, max_len_q;
  logic                squash_q;
  logic [GEN_LAT-1:0]  issue_q, issue_d;
  logic [127:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q, inflight;
  logic [DrnW-1:0]     drain_q;
  logic                found_q, exhausted_q, aborted_q;
  logic [127:0]        found_guess_q;
  logic [47:0]         guess_count_q;

  logic accept_start, active, end_hit, end_abort, flush;
  logic capture, push, pop, drain_last;

  assign capture    = issue_q[GEN_LAT-1];
  assign drain_last = (drain_q == DrnW'(DRAIN_CYC - 1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < GEN_LAT; i++) inflight = inflight + CntW'(issue_q[i]);
  end

  // Issue shift register: a bit reaches the top exactly when its guess is on gen_guess.
  always_comb begin
    issue_d    = '0;
    issue_d[0] = gen_reset | gen_step;
    for (int i = 1; i < GEN_LAT; i++) issue_d[i] = issue_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StLoad;
      StLoad:         state_d = StRun;
      StRun:          if (squash_q && inflight == '0 && count_q == '0) state_d = StNextLen;
      StNextLen:      state_d = (len_q == max_len_q) ? StDrain : StLoad;
      StDrain:        if (drain_last) state_d = StDone;
      default:        state_d = StIdle;
    endcase
    if (flush) state_d = StDone;
  end

  always_comb begin
    active       = (state_q != StIdle) && (state_q != StDone);
    accept_start = start && !active;
    end_hit      = active && hit;
    end_abort    = active && abort && !hit;
    flush        = end_hit || end_abort;
    busy         = active;
    gen_reset    = (state_q == StLoad);
    gen_step     = (state_q == StRun) && !squash_q &&
                   ((count_q + inflight + CntW'(1)) <= CntW'(FIFO_DEPTH));
    out_valid    = (state_q == StRun) && (count_q != '0);
    pop          = out_valid && out_ready;
    push         = capture && !gen_done && !squash_q && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      charset_q     <= '0;
      len_q         <= '0;
      max_len_q     <= '0;
      squash_q      <= 1'b0;
      issue_q       <= '0;
      drain_q       <= '0;
      found_q       <= 1'b0;
      found_guess_q <= '0;
      exhausted_q   <= 1'b0;
      aborted_q     <= 1'b0;
      guess_count_q <= '0;
    end else begin
      if (accept_start) begin
        charset_q     <= cfg_charset;
        len_q         <= cfg_min_len;
        max_len_q     <= cfg_max_len;
        found_q       <= 1'b0;
        found_guess_q <= '0;
        exhausted_q   <= 1'b0;
        aborted_q     <= 1'b0;
        guess_count_q <= '0;
      end else if (pop && guess_count_q != '1) begin
        guess_count_q <= guess_count_q + 48'd1;
      end
      if (state_q == StNextLen && len_q != max_len_q) len_q <= len_q + 4'd1;
      // A wrapped generator poisons every capture until the next reload.
      if (state_q == StLoad)          squash_q <= 1'b0;
      else if (capture && gen_done)   squash_q <= 1'b1;
      issue_q <= flush ? '0 : issue_d;
      drain_q <= (state_q == StDrain) ? drain_q + DrnW'(1) : '0;
      if (state_q == StDrain && drain_last && !flush) exhausted_q <= 1'b1;
      if (end_hit) begin
        found_q       <= 1'b1;
        found_guess_q <= hit_guess;
      end
      if (end_abort) aborted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= gen_guess;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  assign gen_charset = charset_q;
  assign gen_len     = len_q;
  assign out_guess   = mem_q[rptr_q];
  assign found       = found_q;
  assign found_guess = found_guess_q;
  assign exhausted   = exhausted_q;
  assign aborted     = aborted_q;
  assign guess_count = guess_count_q;

endmodule
